// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter for the single RF write port shared by the ALU (A) and
// load-return (B) paths, with a per-register pending scoreboard for issue hazards.
module rf_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_claim_valid,
  input  logic [ADDR_W-1:0] i_claim_addr,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_a3,
  output logic [DATA_W-1:0] o_rf_wd,
  output logic [NREG-1:0]   o_pending
);

  logic              r_rr_b;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_a3;
  logic [DATA_W-1:0] r_rf_wd;
  logic [NREG-1:0]   r_pending;

  logic              w_a_grant;
  logic              w_b_grant;
  logic              w_grant;
  logic [ADDR_W-1:0] w_g_addr;
  logic [DATA_W-1:0] w_g_data;
  logic              w_g_we;
  logic [NREG-1:0]   w_pending_nxt;

  // Ready is gated by reset so nothing is accepted while the port is held idle.
  assign w_a_grant = i_rst_n && i_a_valid && (!i_b_valid || !r_rr_b);
  assign w_b_grant = i_rst_n && i_b_valid && (!i_a_valid ||  r_rr_b);
  assign w_grant   = w_a_grant || w_b_grant;
  assign w_g_addr  = w_a_grant ? i_a_addr : i_b_addr;
  assign w_g_data  = w_a_grant ? i_a_data : i_b_data;
  assign w_g_we    = w_grant && (w_g_addr != '0);

  assign o_a_ready = w_a_grant;
  assign o_b_ready = w_b_grant;

  // A claim on the same edge as a writeback wins: the newer producer is still outstanding.
  always_comb begin
    w_pending_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      w_pending_nxt[i] = (i_claim_valid && (i_claim_addr == ADDR_W'(i))) ||
                         (r_pending[i] && !(w_grant && (w_g_addr == ADDR_W'(i))));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_b    <= 1'b0;
      r_rf_we   <= 1'b0;
      r_rf_a3   <= '0;
      r_rf_wd   <= '0;
      r_pending <= '0;
    end else begin
      r_rf_we   <= w_g_we;
      r_pending <= w_pending_nxt;
      if (w_grant) begin
        r_rr_b  <= w_a_grant;
        r_rf_a3 <= w_g_addr;
        r_rf_wd <= w_g_data;
      end
    end
  end

  assign o_rf_we   = r_rf_we;
  assign o_rf_a3   = r_rf_a3;
  assign o_rf_wd   = r_rf_wd;
  assign o_pending = r_pending;

  // Busy covers the RF write cycle too, so the first non-busy read sees the new value.
  assign o_rs1_busy = (i_rs1_addr != '0) &&
                      (r_pending[i_rs1_addr] || (r_rf_we && (r_rf_a3 == i_rs1_addr)));
  assign o_rs2_busy = (i_rs2_addr != '0) &&
                      (r_pending[i_rs2_addr] || (r_rf_we && (r_rf_a3 == i_rs2_addr)));

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: reset, solo/contended writebacks,
// scoreboard hazards, x0 handling and mid-operation reset.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        claim_valid;
  logic [4:0]  claim_addr, rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] pending;
  logic [31:0] tb_rf [32];

  int checks   = 0;
  int failures = 0;

  rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_claim_valid(claim_valid), .i_claim_addr(claim_addr),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_rf_we(rf_we), .o_rf_a3(rf_a3), .o_rf_wd(rf_wd), .o_pending(pending)
  );

  always #5 clk = ~clk;

  // Stand-in register file capturing the write port.
  always @(posedge clk) if (rf_we) tb_rf[rf_a3] <= rf_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; claim_valid = 0; claim_addr = 0; rs1_addr = 0; rs2_addr = 0;
    a_valid = 1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1; b_addr = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 32; i++) tb_rf[i] = '0;

    // 1 reset with both requesters valid
    tick(); tick();
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_rf_we",   rf_we,   0);
    check("rst_pending", pending, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("post_rst_a_first", a_ready, 1);
    check("post_rst_b_wait",  b_ready, 0);
    tick();
    check("rr_b_second", b_ready, 1);
    check("rr_a_blocked", a_ready, 0);
    check("rst_wb_we", rf_we, 1);
    check("rst_wb_a3", rf_a3, 1);
    tick();
    a_valid = 0; b_valid = 0;
    check("rst_wb2_a3", rf_a3, 2);
    check("rst_wb2_wd", rf_wd, 32'h22);
    tick();
    check("idle_we", rf_we, 0);

    // 2 solo A to x8, then solo B to x9 to put the pointer back on A
    a_valid = 1; a_addr = 5'd8; a_data = 32'h0000_00FF; #1;
    check("solo_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    check("solo_we", rf_we, 1);
    check("solo_a3", rf_a3, 8);
    check("solo_wd", rf_wd, 32'hFF);
    tick();
    check("solo_rf_x8", tb_rf[8], 32'hFF);
    b_valid = 1; b_addr = 5'd9; b_data = 32'h99; #1;
    check("solo_b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    check("solo_b_a3", rf_a3, 9);

    // 3 contention: expect A,B,A,B
    a_valid = 1; a_addr = 5'd6; a_data = 32'h66;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h77; #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cont_a_ready%0d", k), a_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("cont_b_ready%0d", k), b_ready, (k % 2 == 0) ? 0 : 1);
      tick();
      check($sformatf("cont_a3_%0d", k), rf_a3, (k % 2 == 0) ? 6 : 7);
      check($sformatf("cont_wd_%0d", k), rf_wd, (k % 2 == 0) ? 32'h66 : 32'h77);
    end
    a_valid = 0; b_valid = 0;
    tick();

    // 4 scoreboard on x6
    claim_valid = 1; claim_addr = 5'd6; rs1_addr = 5'd6; rs2_addr = 5'd6; #1;
    check("sb_busy_t", rs1_busy, 0);
    tick();
    claim_valid = 0;
    check("sb_busy_t1", rs1_busy, 1);
    check("sb_busy2_t1", rs2_busy, 1);
    check("sb_pend_t1", pending, 32'h40);
    tick();
    b_valid = 1; b_addr = 5'd6; b_data = 32'h1234; #1;
    check("sb_b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    check("sb_busy_t4", rs1_busy, 1);
    check("sb_pend_t4", pending, 0);
    check("sb_we_t4", rf_we, 1);
    tick();
    check("sb_busy_t5", rs1_busy, 0);
    check("sb_rf_x6", tb_rf[6], 32'h1234);

    // same-edge claim and writeback of x6: set wins
    claim_valid = 1; claim_addr = 5'd6; tick();
    check("same_pre_pend", pending, 32'h40);
    a_valid = 1; a_addr = 5'd6; a_data = 32'h5; #1;
    check("same_a_ready", a_ready, 1);
    tick();
    claim_valid = 0; a_valid = 0;
    check("same_pend", pending, 32'h40);
    b_valid = 1; b_addr = 5'd6; b_data = 32'h6; tick();
    b_valid = 0;
    check("clear_pend", pending, 0);
    a_valid = 1; a_addr = 5'd10; a_data = 32'hA; tick();
    a_valid = 0;
    check("noop_clear_pend", pending, 0);

    // 5 x0
    a_valid = 1; a_addr = 5'd0; a_data = 32'hDEAD_BEEF;
    claim_valid = 1; claim_addr = 5'd0; rs1_addr = 5'd0; #1;
    check("x0_a_ready", a_ready, 1);
    check("x0_busy", rs1_busy, 0);
    tick();
    a_valid = 0; claim_valid = 0;
    check("x0_we", rf_we, 0);
    check("x0_pend", pending, 0);
    check("x0_busy_after", rs1_busy, 0);

    // 6 reset during the write cycle
    a_valid = 1; a_addr = 5'd11; a_data = 32'hB;
    claim_valid = 1; claim_addr = 5'd12; #1;
    check("mid_a_ready", a_ready, 1);
    tick();
    a_valid = 0; claim_valid = 0;
    check("mid_we_pre", rf_we, 1);
    check("mid_pend_pre", pending, 32'h1000);
    rst_n = 1'b0; #1;
    check("mid_we_rst", rf_we, 0);
    check("mid_pend_rst", pending, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("mid_we_after", rf_we, 0);
    check("mid_rf_x11", tb_rf[11], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
